conv_loop_sequencer: RTL and testbench

Loop-nest scheduler for the convolution datapath. On a start pulse it walks the indices m, r, c, n, i, j over one full layer and presents them to the address generator, one index set per cycle. It flags the first and last accumulation term of every output pixel and issues the output-buffer write strobe after the datapath pipeline delay. It reports busy and done to the top-level control.

---
 rtl/conv_loop_sequencer_if.sv | 25 ++
 rtl/conv_loop_sequencer.sv | 91 +++++++++
 tb/tb_conv_loop_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/conv_loop_sequencer_if.sv
// conv_loop_sequencer_if: launch/stall control and index-beat outputs of the loop-nest sequencer
interface conv_loop_sequencer_if;
  logic       start;
  logic       stall;
  logic [7:0] m;
  logic [7:0] r;
  logic [7:0] c;
  logic [7:0] n;
  logic [3:0] i;
  logic [3:0] j;
  logic       idx_valid;
  logic       acc_first;
  logic       acc_last;
  logic       out_wea;
  logic       busy;
  logic       done;
  modport master (
    output start, stall,
    input  m, r, c, n, i, j, idx_valid, acc_first, acc_last, out_wea, busy, done
  );
  modport slave (
    input  start, stall,
    output m, r, c, n, i, j, idx_valid, acc_first, acc_last, out_wea, busy, done
  );
endinterface

// File: rtl/conv_loop_sequencer.sv
// conv_loop_sequencer: walks the m/r/c/n/i/j loop nest of one layer and strobes output-buffer writes
module conv_loop_sequencer #(
  parameter int K          = 5,
  parameter int OUT_SIZE   = 28,
  parameter int OUT_CHAN   = 6,
  parameter int IN_CHAN    = 4,
  parameter int N_PAR      = 4,
  parameter int PIPE_DEPTH = 9
) (
  input logic clock,
  input logic reset,
  conv_loop_sequencer_if.slave bus
);
  localparam int DW = $clog2(PIPE_DEPTH + 1);
  localparam logic [3:0] K_MAX = 4'(K - 1);
  localparam logic [7:0] OS_MAX = 8'(OUT_SIZE - 1);
  localparam logic [7:0] OC_MAX = 8'(OUT_CHAN - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] m_q, m_d, r_q, r_d, c_q, c_d, n_q, n_d;
  logic [3:0] i_q, i_d, j_q, j_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [PIPE_DEPTH-1:0] wea_q, wea_d;
  logic adv, last_i, last_j, last_n, last_c, last_r, last_m;
  logic step_i, step_n, step_c, step_r, step_m, fin, acc_last;
  // nest advance (innermost first, carries outward), FSM next state and write-strobe delay line
  always_comb begin
    adv      = state_q == RUN && !bus.stall;
    last_j   = j_q == K_MAX;
    last_i   = i_q == K_MAX;
    last_n   = ({1'b0, n_q} + 9'(N_PAR)) >= 9'(IN_CHAN);
    last_c   = c_q == OS_MAX;
    last_r   = r_q == OS_MAX;
    last_m   = m_q == OC_MAX;
    step_i   = adv & last_j;
    step_n   = step_i & last_i;
    step_c   = step_n & last_n;
    step_r   = step_c & last_c;
    step_m   = step_r & last_r;
    fin      = step_m & last_m;
    acc_last = adv & last_n & last_i & last_j;
    j_d      = adv ? (last_j ? '0 : j_q + 4'd1) : j_q;
    i_d      = step_i ? (last_i ? '0 : i_q + 4'd1) : i_q;
    n_d      = step_n ? (last_n ? '0 : n_q + 8'(N_PAR)) : n_q;
    c_d      = step_c ? (last_c ? '0 : c_q + 8'd1) : c_q;
    r_d      = step_r ? (last_r ? '0 : r_q + 8'd1) : r_q;
    m_d      = step_m ? (last_m ? '0 : m_q + 8'd1) : m_q;
    drain_d  = state_q == DRAIN ? drain_q + 1'b1 : '0;
    wea_d    = (wea_q << 1) | PIPE_DEPTH'(acc_last);
    state_d  = state_q == IDLE  ? (bus.start ? RUN : IDLE) :
               state_q == RUN   ? (fin ? DRAIN : RUN) :
               state_q == DRAIN ? (drain_q == DW'(PIPE_DEPTH - 1) ? DONE : DRAIN) :
                                  IDLE;
  end
  // state, index counters and delay line; reset abandons any layer in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      drain_q <= '0;
      wea_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      r_q     <= r_d;
      c_q     <= c_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      drain_q <= drain_d;
      wea_q   <= wea_d;
    end
  end
  assign bus.m         = m_q;
  assign bus.r         = r_q;
  assign bus.c         = c_q;
  assign bus.n         = n_q;
  assign bus.i         = i_q;
  assign bus.j         = j_q;
  assign bus.idx_valid = adv;
  assign bus.acc_first = adv && n_q == '0 && i_q == '0 && j_q == '0;
  assign bus.acc_last  = acc_last;
  assign bus.out_wea   = wea_q[PIPE_DEPTH-1];
  assign bus.busy      = state_q == RUN || state_q == DRAIN;
  assign bus.done      = state_q == DONE;
endmodule

// File: tb/tb_conv_loop_sequencer.sv
// tb_conv_loop_sequencer: random start/stall/reset against a beat-list reference model
module tb_conv_loop_sequencer;
  localparam int K = 2, OS = 2, OC = 2, IC = 6, NP = 4, PD = 9;
  logic clock = 0;
  logic reset = 1;
  conv_loop_sequencer_if bus();
  conv_loop_sequencer #(.K(K), .OUT_SIZE(OS), .OUT_CHAN(OC), .IN_CHAN(IC), .N_PAR(NP), .PIPE_DEPTH(PD))
    dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  typedef struct {int m; int r; int c; int n; int i; int j;} beat_t;
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mode_t;
  beat_t beats[$];
  bit wea_due[int];
  mode_t mode = M_IDLE;
  int checks = 0, failures = 0, cyc = 0, k = 0, drain_left = 0;
  int done_exp = 0, done_seen = 0, first_done = -1;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, act, exp);
    end
  endtask
  initial begin
    beat_t b, z;
    bit v, f, l, w, rst_now;
    z = '{0, 0, 0, 0, 0, 0};
    for (int mm = 0; mm < OC; mm++)
      for (int rr = 0; rr < OS; rr++)
        for (int cc = 0; cc < OS; cc++)
          for (int nn = 0; nn < IC; nn += NP)
            for (int ii = 0; ii < K; ii++)
              for (int jj = 0; jj < K; jj++)
                beats.push_back('{mm, rr, cc, nn, ii, jj});
    bus.start = 0;
    bus.stall = 0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.idx_valid, 0);
    chk("rst_wea", bus.out_wea, 0);
    chk("rst_m", bus.m, 0);
    chk("rst_j", bus.j, 0);
    reset = 0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clock);
      cyc++;
      bus.start = (t == 0) || ($urandom_range(0, 3) == 0);
      bus.stall = (t >= 90) && ($urandom_range(0, 3) == 0);
      rst_now   = (t >= 200) && ($urandom_range(0, 249) == 0);
      if (reset) reset = 0;
      else if (rst_now) reset = 1;
      #1;
      v = !reset && mode == M_RUN && !bus.stall;
      b = (!reset && mode == M_RUN) ? beats[k] : z;
      f = v && b.n == 0 && b.i == 0 && b.j == 0;
      l = v && b.n + NP >= IC && b.i == K - 1 && b.j == K - 1;
      w = !reset && wea_due.exists(cyc);
      chk("m", bus.m, b.m);
      chk("r", bus.r, b.r);
      chk("c", bus.c, b.c);
      chk("n", bus.n, b.n);
      chk("i", bus.i, b.i);
      chk("j", bus.j, b.j);
      chk("idx_valid", bus.idx_valid, v);
      chk("acc_first", bus.acc_first, f);
      chk("acc_last", bus.acc_last, l);
      chk("out_wea", bus.out_wea, w);
      chk("busy", bus.busy, !reset && (mode == M_RUN || mode == M_DRAIN));
      chk("done", bus.done, !reset && mode == M_DONE);
      if (bus.done === 1'b1) begin
        done_seen++;
        if (first_done < 0) first_done = cyc;
      end
      if (wea_due.exists(cyc)) wea_due.delete(cyc);
      if (reset) begin
        mode = M_IDLE;
        k = 0;
        wea_due.delete();
      end else if (mode == M_IDLE) begin
        if (bus.start) begin
          mode = M_RUN;
          k = 0;
        end
      end else if (mode == M_RUN) begin
        if (v) begin
          if (l) wea_due[cyc + PD] = 1;
          k++;
          if (k == beats.size()) begin
            mode = M_DRAIN;
            drain_left = PD;
            k = 0;
          end
        end
      end else if (mode == M_DRAIN) begin
        drain_left--;
        if (drain_left == 0) mode = M_DONE;
      end else begin
        mode = M_IDLE;
        done_exp++;
      end
    end
    chk("first_done_cycle", first_done, 1 + beats.size() + PD + 1);
    chk("done_count", done_seen, done_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
